// File: rtl/conv5_window_feeder.sv
// Streaming front end for the 5x5 conv engine: loads kernel columns, buffers four
// image rows and emits column beats plus a result-capture strobe tagged with coordinates.
module conv5_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         weight_in,
  input  logic                          weight_valid,
  output logic                          weight_ready,
  input  logic [DATA_WIDTH-1:0]         pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [DATA_WIDTH-1:0]         conv_d0,
  output logic [DATA_WIDTH-1:0]         conv_d1,
  output logic [DATA_WIDTH-1:0]         conv_d2,
  output logic [DATA_WIDTH-1:0]         conv_d3,
  output logic [DATA_WIDTH-1:0]         conv_d4,
  output logic                          conv_valid_in,
  output logic                          conv_kernel_load,
  output logic                          conv_valid_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] res_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  res_col,
  output logic                          busy,
  output logic                          done
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, KERNEL, STREAM, DRAIN} state_t;
  state_t state_reg, state_next;

  logic            w_acc, p_acc, last_weight, last_pix, kcol_full, pix_beat;
  logic [2:0]      wrow_reg, wcol_reg;
  logic [RW-1:0]   row_reg;
  logic [CW-1:0]   col_reg;
  logic [DATA_WIDTH-1:0] kbuf_reg [4];
  logic [DATA_WIDTH-1:0] lb [IMG_WIDTH][4];
  logic [DATA_WIDTH-1:0] src_lane [5];
  logic [DATA_WIDTH-1:0] lane_reg [5];
  logic            beat_reg, kload_reg, p1_reg, p2_reg, out_reg, done_reg;
  logic [RW-1:0]   p1_row_reg, p2_row_reg, res_row_reg;
  logic [CW-1:0]   p1_col_reg, p2_col_reg, res_col_reg;

  assign weight_ready = (state_reg == KERNEL);
  assign pix_ready    = (state_reg == STREAM);
  assign busy         = (state_reg != IDLE);
  assign w_acc        = weight_valid & weight_ready;
  assign p_acc        = pix_valid & pix_ready;
  assign kcol_full    = (wrow_reg == 3'd4);
  assign last_weight  = kcol_full && (wcol_reg == 3'd4);
  assign last_pix     = (row_reg == RW'(IMG_HEIGHT - 1)) && (col_reg == CW'(IMG_WIDTH - 1));
  assign pix_beat     = p_acc && (row_reg >= RW'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = KERNEL;
      KERNEL:  if (w_acc && last_weight) state_next = STREAM;
      STREAM:  if (p_acc && last_pix) state_next = DRAIN;
      // the final window sits in p1 for one cycle; once it has moved on, done can fire
      DRAIN:   if (!p1_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrow_reg <= '0;
      wcol_reg <= '0;
      row_reg  <= '0;
      col_reg  <= '0;
    end else if (state_reg == IDLE && start) begin
      wrow_reg <= '0;
      wcol_reg <= '0;
      row_reg  <= '0;
      col_reg  <= '0;
    end else if (w_acc) begin
      if (kcol_full) begin
        wrow_reg <= '0;
        wcol_reg <= (wcol_reg == 3'd4) ? 3'd0 : wcol_reg + 3'd1;
      end else begin
        wrow_reg <= wrow_reg + 3'd1;
      end
    end else if (p_acc) begin
      if (col_reg == CW'(IMG_WIDTH - 1)) begin
        col_reg <= '0;
        row_reg <= (row_reg == RW'(IMG_HEIGHT - 1)) ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Storage only; every entry is overwritten before it is read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_acc && !kcol_full) kbuf_reg[wrow_reg[1:0]] <= weight_in;
    if (p_acc) begin
      lb[col_reg][0] <= lb[col_reg][1];
      lb[col_reg][1] <= lb[col_reg][2];
      lb[col_reg][2] <= lb[col_reg][3];
      lb[col_reg][3] <= pix_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign src_lane[gi] = w_acc ? kbuf_reg[gi] : lb[col_reg][gi];
    end
  endgenerate
  assign src_lane[4] = w_acc ? weight_in : pix_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) lane_reg[i] <= '0;
      beat_reg    <= 1'b0;
      kload_reg   <= 1'b0;
      p1_reg      <= 1'b0;
      p2_reg      <= 1'b0;
      out_reg     <= 1'b0;
      done_reg    <= 1'b0;
      p1_row_reg  <= '0;
      p1_col_reg  <= '0;
      p2_row_reg  <= '0;
      p2_col_reg  <= '0;
      res_row_reg <= '0;
      res_col_reg <= '0;
    end else begin
      beat_reg  <= (w_acc && kcol_full) || pix_beat;
      kload_reg <= w_acc && kcol_full;
      if ((w_acc && kcol_full) || pix_beat) begin
        for (int i = 0; i < 5; i++) lane_reg[i] <= src_lane[i];
      end
      // p1 lines up with the beat, p2 with the engine buffer load, out with the result
      p1_reg      <= pix_beat && (col_reg >= CW'(4));
      p1_row_reg  <= row_reg - RW'(4);
      p1_col_reg  <= col_reg - CW'(4);
      p2_reg      <= p1_reg;
      p2_row_reg  <= p1_row_reg;
      p2_col_reg  <= p1_col_reg;
      out_reg     <= p2_reg;
      res_row_reg <= p2_reg ? p2_row_reg : '0;
      res_col_reg <= p2_reg ? p2_col_reg : '0;
      done_reg    <= (state_reg == DRAIN) && !p1_reg;
    end
  end

  assign conv_d0          = lane_reg[0];
  assign conv_d1          = lane_reg[1];
  assign conv_d2          = lane_reg[2];
  assign conv_d3          = lane_reg[3];
  assign conv_d4          = lane_reg[4];
  assign conv_valid_in    = beat_reg;
  assign conv_kernel_load = kload_reg;
  assign conv_valid_out   = out_reg;
  assign res_row          = res_row_reg;
  assign res_col          = res_col_reg;
  assign done             = done_reg;
endmodule

// File: tb/tb_conv5_window_feeder.sv
// Scoreboard bench for conv5_window_feeder on an 8x6 frame: expected beats, captures
// and done are queued as stimulus is accepted and compared as the DUT emits them.
module tb_conv5_window_feeder;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic weight_valid = 1'b0, pix_valid = 1'b0;
  logic [DW-1:0] weight_in = '0, pix_in = '0;
  logic weight_ready, pix_ready, conv_valid_in, conv_kernel_load, conv_valid_out, busy, done;
  logic [DW-1:0] conv_d0, conv_d1, conv_d2, conv_d3, conv_d4;
  logic [$clog2(H)-1:0] res_row;
  logic [$clog2(W)-1:0] res_col;

  conv5_window_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .weight_in(weight_in), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .conv_d0(conv_d0), .conv_d1(conv_d1), .conv_d2(conv_d2), .conv_d3(conv_d3), .conv_d4(conv_d4),
    .conv_valid_in(conv_valid_in), .conv_kernel_load(conv_kernel_load),
    .conv_valid_out(conv_valid_out), .res_row(res_row), .res_col(res_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { int cyc; logic kl; logic [5*DW-1:0] lanes; } beat_t;
  typedef struct packed { int cyc; int row; int col; } cap_t;

  beat_t beat_q[$];
  cap_t  cap_q[$];
  cap_t  obs_caps[$];
  int    done_q[$];
  int    cyc = 0, n_tests = 0, n_fail = 0;
  int    n_kbeats = 0, n_pbeats = 0, n_dones = 0;
  int    acc_cyc[H][W];

  function automatic logic [DW-1:0] pv(input int base, input int r, input int c);
    return DW'(base + W * r + c);
  endfunction

  // Monitor: samples on the falling edge, pops and compares expected traffic.
  always @(negedge clk) begin
    beat_t got_b, exp_b;
    cap_t  got_c, exp_c;
    int    exp_d;
    cyc = cyc + 1;
    if (rst_n) begin
      if (conv_valid_in) begin
        got_b = '{cyc: cyc, kl: conv_kernel_load, lanes: {conv_d0, conv_d1, conv_d2, conv_d3, conv_d4}};
        if (conv_kernel_load) n_kbeats++; else n_pbeats++;
        n_tests++;
        if (beat_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected cyc=%0d kl=%0b lanes=%h required=none", cyc, conv_kernel_load, got_b.lanes);
        end else begin
          exp_b = beat_q.pop_front();
          if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL beat cyc=%0d kl=%0b lanes=%h required cyc=%0d kl=%0b lanes=%h",
                     got_b.cyc, got_b.kl, got_b.lanes, exp_b.cyc, exp_b.kl, exp_b.lanes);
          end
        end
      end else begin
        n_tests++;
        if (conv_kernel_load !== 1'b0) begin
          n_fail++;
          $display("FAIL kload_idle cyc=%0d got=%b required=0", cyc, conv_kernel_load);
        end
      end
      if (conv_valid_out) begin
        got_c = '{cyc: cyc, row: int'(res_row), col: int'(res_col)};
        obs_caps.push_back(got_c);
        n_tests++;
        if (cap_q.size() == 0) begin
          n_fail++;
          $display("FAIL cap_unexpected cyc=%0d tag=(%0d,%0d) required=none", cyc, res_row, res_col);
        end else begin
          exp_c = cap_q.pop_front();
          if (got_c !== exp_c) begin
            n_fail++;
            $display("FAIL cap cyc=%0d tag=(%0d,%0d) required cyc=%0d tag=(%0d,%0d)",
                     got_c.cyc, got_c.row, got_c.col, exp_c.cyc, exp_c.row, exp_c.col);
          end
        end
      end else begin
        n_tests++;
        if ({res_row, res_col} !== '0) begin
          n_fail++;
          $display("FAIL res_idle cyc=%0d tag=(%0d,%0d) required=(0,0)", cyc, res_row, res_col);
        end
      end
      if (done) begin
        n_dones++;
        n_tests++;
        exp_d = (done_q.size() != 0) ? done_q.pop_front() : -1;
        if (exp_d != cyc || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done cyc=%0d busy=%b required cyc=%0d busy=0", cyc, busy, exp_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_weights(input int base, input int nw);
    bit rdy;
    int n, guard;
    for (int i = 0; i < nw; i++) begin
      weight_valid = 1'b1;
      weight_in    = DW'(base + i + 1);
      guard = 0;
      do begin
        rdy = weight_ready; n = cyc + 1;
        @(posedge clk); #1; guard++;
      end while (!rdy && guard < 20);
      if (!rdy) begin
        n_tests++; n_fail++;
        $display("FAIL weight_handshake timeout at weight %0d got=no accept required=accept", i);
      end
      if (i % 5 == 4)
        beat_q.push_back('{cyc: n + 1, kl: 1'b1,
                           lanes: {DW'(base + i - 3), DW'(base + i - 2), DW'(base + i - 1), DW'(base + i), DW'(base + i + 1)}});
    end
    weight_valid = 1'b0;
  endtask

  task automatic drive_pixels(input int base, input int gap, input int npix, input int start_at);
    bit rdy;
    int n, guard, idx;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (idx < npix) begin
          while ($urandom_range(99) < gap) begin
            pix_valid = 1'b0; start = 1'b0;
            @(posedge clk); #1;
          end
          pix_valid = 1'b1;
          pix_in    = pv(base, r, c);
          start     = (idx == start_at);
          guard = 0;
          do begin
            rdy = pix_ready; n = cyc + 1;
            @(posedge clk); #1; guard++;
            start = 1'b0;
          end while (!rdy && guard < 20);
          if (!rdy) begin
            n_tests++; n_fail++;
            $display("FAIL pix_handshake timeout at (%0d,%0d) got=no accept required=accept", r, c);
          end
          acc_cyc[r][c] = n;
          if (r >= 4) begin
            beat_q.push_back('{cyc: n + 1, kl: 1'b0,
                               lanes: {pv(base, r-4, c), pv(base, r-3, c), pv(base, r-2, c), pv(base, r-1, c), pv(base, r, c)}});
            if (c >= 4) cap_q.push_back('{cyc: n + 3, row: r - 4, col: c - 4});
          end
          if (r == H - 1 && c == W - 1) done_q.push_back(n + 3);
          idx++;
        end
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while ((beat_q.size() + cap_q.size() + done_q.size()) != 0 && g < budget) begin
      @(posedge clk); #1; g++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic clear_queues();
    beat_q.delete(); cap_q.delete(); done_q.delete(); obs_caps.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if ({busy, weight_ready, pix_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle busy/wready/pready got=%b required=000", {busy, weight_ready, pix_ready});
    end
    n_tests++;
    if ({conv_valid_in, conv_valid_out, conv_kernel_load, done, conv_d0, conv_d4} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got vin=%b vout=%b kl=%b done=%b d0=%h d4=%h required all 0",
               conv_valid_in, conv_valid_out, conv_kernel_load, done, conv_d0, conv_d4);
    end
    // Async reset asserted in the middle of a kernel beat cycle.
    do_start();
    drive_weights(100, 5);
    n_tests++;
    if (conv_valid_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prebeat conv_valid_in got=%b required=1", conv_valid_in);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, weight_ready, pix_ready, conv_valid_in, conv_valid_out, conv_kernel_load, done} !== 7'b0 ||
        {conv_d0, conv_d1, conv_d2, conv_d3, conv_d4, res_row, res_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got busy=%b vin=%b kl=%b d0=%h d4=%h required all 0",
               busy, conv_valid_in, conv_kernel_load, conv_d0, conv_d4);
    end
    clear_queues();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if ({busy, weight_ready, pix_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release busy/wready/pready got=%b required=000", {busy, weight_ready, pix_ready});
    end
  endtask

  task automatic test_kernel();
    int kb0;
    kb0 = n_kbeats;
    do_start();
    drive_weights(0, 25);
    n_tests++;
    if (weight_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kernel_ready_drop weight_ready=%b busy=%b required weight_ready=0 busy=1", weight_ready, busy);
    end
    wait_drain(10);
    n_tests++;
    if (beat_q.size() != 0 || n_kbeats - kb0 != 5) begin
      n_fail++;
      $display("FAIL kernel_beats got=%0d pending=%0d required=5 pending=0", n_kbeats - kb0, beat_q.size());
    end
  endtask

  task automatic test_small_frame();
    int d0;
    obs_caps.delete();
    d0 = n_dones;
    drive_pixels(0, 0, W * H, -1);
    wait_drain(20);
    n_tests++;
    if (beat_q.size() + cap_q.size() + done_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_pending got beats=%0d caps=%0d done=%0d required 0", beat_q.size(), cap_q.size(), done_q.size());
    end
    n_tests++;
    if (obs_caps.size() != (W - 4) * (H - 4) || n_dones - d0 != 1) begin
      n_fail++;
      $display("FAIL frame_counts caps=%0d dones=%0d required caps=%0d dones=1", obs_caps.size(), n_dones - d0, (W - 4) * (H - 4));
    end
    n_tests++;
    if (obs_caps.size() == 0 || obs_caps[0] !== cap_t'{cyc: acc_cyc[4][4] + 3, row: 0, col: 0}) begin
      n_fail++;
      $display("FAIL frame_first_cap got cyc=%0d tag=(%0d,%0d) required cyc=%0d tag=(0,0)",
               (obs_caps.size() != 0) ? obs_caps[0].cyc : -1, (obs_caps.size() != 0) ? obs_caps[0].row : -1,
               (obs_caps.size() != 0) ? obs_caps[0].col : -1, acc_cyc[4][4] + 3);
    end
  endtask

  task automatic test_gaps();
    int bad;
    obs_caps.delete();
    do_start();
    drive_weights(300, 25);
    drive_pixels(0, 30, W * H, -1);
    wait_drain(40);
    bad = 0;
    foreach (obs_caps[i])
      if (obs_caps[i].cyc != acc_cyc[obs_caps[i].row + 4][obs_caps[i].col + 4] + 3) bad++;
    n_tests++;
    if (bad != 0 || obs_caps.size() != (W - 4) * (H - 4) || beat_q.size() + cap_q.size() + done_q.size() != 0) begin
      n_fail++;
      $display("FAIL gaps_offset misaligned=%0d caps=%0d pending=%0d required 0/%0d/0",
               bad, obs_caps.size(), beat_q.size() + cap_q.size() + done_q.size(), (W - 4) * (H - 4));
    end
  endtask

  task automatic test_row_boundary();
    int early, hit;
    obs_caps.delete();
    do_start();
    drive_weights(400, 25);
    drive_pixels(1000, 0, W * H, -1);
    wait_drain(20);
    early = 0; hit = 0;
    foreach (obs_caps[i]) begin
      for (int c = 0; c < 4; c++)
        if (obs_caps[i].cyc == acc_cyc[5][c] + 3) early++;
      if (obs_caps[i].cyc == acc_cyc[5][4] + 3 && obs_caps[i].row == 1 && obs_caps[i].col == 0) hit++;
    end
    n_tests++;
    if (early != 0 || hit != 1) begin
      n_fail++;
      $display("FAIL row_boundary caps_for_c<4=%0d tagged_(1,0)=%0d required 0 and 1", early, hit);
    end
  endtask

  task automatic test_abort_restart();
    int d0, pb0;
    do_start();
    drive_weights(50, 25);
    drive_pixels(2000, 0, 20, -1);
    d0 = n_dones;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, pix_ready, conv_valid_in, conv_valid_out, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_async got busy=%b pready=%b vin=%b vout=%b done=%b required 0",
               busy, pix_ready, conv_valid_in, conv_valid_out, done);
    end
    clear_queues();
    @(posedge clk); #1 rst_n = 1'b1;
    pb0 = n_pbeats;
    repeat (10) begin @(posedge clk); #1; end
    n_tests++;
    if (n_dones != d0 || n_pbeats != pb0 || obs_caps.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet dones=%0d beats=%0d caps=%0d busy=%b required 0/0/0/0",
               n_dones - d0, n_pbeats - pb0, obs_caps.size(), busy);
    end
    do_start();
    drive_weights(60, 25);
    drive_pixels(3000, 0, W * H, 10);
    wait_drain(20);
    n_tests++;
    if (n_dones - d0 != 1 || obs_caps.size() != (W - 4) * (H - 4) || beat_q.size() + cap_q.size() + done_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_frame dones=%0d caps=%0d pending=%0d required 1/%0d/0",
               n_dones - d0, obs_caps.size(), beat_q.size() + cap_q.size() + done_q.size(), (W - 4) * (H - 4));
    end
  endtask

  initial begin
    test_reset();
    test_kernel();
    test_small_frame();
    test_gaps();
    test_row_boundary();
    test_abort_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
